rptr_empty: RTL and testbench

Read-domain control half of the asynchronous FIFO. It brings the Gray-coded write pointer into the read clock through a two-flop synchronizer and maintains the binary and Gray read pointers. It generates a registered empty flag, plus an optional level and almost-empty indication. It drives the dual-port RAM read address and exports the Gray read pointer for synchronization into the write domain.

---
 rtl/rptr_empty.sv | 99 +++++++++
 tb/tb_rptr_empty.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/rptr_empty.sv
// rptr_empty: read-domain control half of an asynchronous FIFO.
// Brings the Gray write pointer into rclk through a two-flop synchronizer,
// keeps the binary and Gray read pointers, and flags empty and underflow.
// Optional feature macro RPTR_LEVEL_EN: when defined, the occupancy level
// and the almost-empty threshold compare are built. When it is undefined,
// rlevel is tied to 0 and ralmost_empty mirrors rempty.
module rptr_empty #(
  parameter int ADDRSIZE  = 4,
  parameter int AE_THRESH = 2
) (
  input  logic                rclk,
  input  logic                rst_n,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   wptr_gray,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr_gray,
  output logic                rempty,
  output logic                ralmost_empty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                runderflow
);

  logic [ADDRSIZE:0] wq1;
  logic [ADDRSIZE:0] wq2;
  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] rbin_next;
  logic [ADDRSIZE:0] rgray_next;
  logic              accept;

  // Two-flop synchronizer for the write pointer; only wq2 feeds any logic.
  always_ff @(posedge rclk) begin
    if (!rst_n) begin
      wq1 <= '0;
      wq2 <= '0;
    end else begin
      wq1 <= wptr_gray;
      wq2 <= wq1;
    end
  end

  // Next read pointer: advance only on a read that is not blocked by empty.
  always_comb begin
    accept     = rinc & ~rempty;
    rbin_next  = rbin + {{ADDRSIZE{1'b0}}, accept};
    rgray_next = (rbin_next >> 1) ^ rbin_next;
  end

  // Pointer, empty and sticky underflow registers. Empty compares the new
  // read pointer against the write pointer already held in wq2.
  always_ff @(posedge rclk) begin
    if (!rst_n) begin
      rbin       <= '0;
      rptr_gray  <= '0;
      rempty     <= 1'b1;
      runderflow <= 1'b0;
    end else begin
      rbin      <= rbin_next;
      rptr_gray <= rgray_next;
      rempty    <= (rgray_next == wq2);
      if (rinc && rempty) begin
        runderflow <= 1'b1;
      end
    end
  end

  assign raddr = rbin[ADDRSIZE-1:0];

`ifdef RPTR_LEVEL_EN
  localparam logic [ADDRSIZE:0] AE_LIMIT = AE_THRESH[ADDRSIZE:0];

  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] level_next;

  // Gray-to-binary of the synchronized write pointer, then the occupancy
  // after this edge's read (modulo pointer width, so wrap is handled).
  always_comb begin
    wbin = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      wbin[i] = ^(wq2 >> i);
    end
    level_next = wbin - rbin_next;
  end

  // Registered level and almost-empty so outputs have no input-to-output path.
  always_ff @(posedge rclk) begin
    if (!rst_n) begin
      rlevel        <= '0;
      ralmost_empty <= 1'b1;
    end else begin
      rlevel        <= level_next;
      ralmost_empty <= (level_next <= AE_LIMIT);
    end
  end
`else
  assign rlevel        = '0;
  assign ralmost_empty = rempty;
`endif

endmodule

// File: tb/tb_rptr_empty.sv
// tb_rptr_empty: directed scoreboard bench for rptr_empty.
// Stimulus pushes the expected post-edge outputs into a queue; a monitor
// pops one entry after each rclk edge and compares every output.
module tb_rptr_empty;

  logic       rclk;
  logic       rst_n;
  logic       rinc;
  logic [4:0] wptr_gray;
  logic [3:0] raddr;
  logic [4:0] rptr_gray;
  logic       rempty;
  logic       ralmost_empty;
  logic [4:0] rlevel;
  logic       runderflow;

  typedef struct {
    logic [3:0] raddr;
    logic [4:0] gray;
    logic       empty;
    logic       ae;
    logic [4:0] level;
    logic       uf;
    int         id;
  } exp_t;

  exp_t sb[$];
  exp_t mon_cur;
  int   passCount  = 0;
  int   checkCount = 0;
  int   stepId     = 0;

  rptr_empty #(.ADDRSIZE(4), .AE_THRESH(2)) dut (
    .rclk          (rclk),
    .rst_n         (rst_n),
    .rinc          (rinc),
    .wptr_gray     (wptr_gray),
    .raddr         (raddr),
    .rptr_gray     (rptr_gray),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
    .rlevel        (rlevel),
    .runderflow    (runderflow)
  );

  // Free-running read clock, rising edges at 5, 15, 25, ...
  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  function automatic exp_t mk(input logic [3:0] a, input logic [4:0] g,
                              input logic e, input logic ae,
                              input logic [4:0] l, input logic uf);
    exp_t r;
    r.raddr = a;
    r.gray  = g;
    r.empty = e;
    r.ae    = ae;
    r.level = l;
    r.uf    = uf;
    r.id    = 0;
    return r;
  endfunction

  function automatic logic [4:0] g5(input int k);
    logic [4:0] b;
    b = 5'(k);
    return b ^ (b >> 1);
  endfunction

  // Drive inputs on the falling edge and record what the next rising edge must produce.
  task automatic applyStimulus(input logic rn, input logic ri,
                               input logic [4:0] wg, input exp_t e);
    @(negedge rclk);
    rst_n     = rn;
    rinc      = ri;
    wptr_gray = wg;
    e.id      = stepId;
    stepId++;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input string name, input int id,
                             input logic [31:0] act, input logic [31:0] expv);
    checkCount++;
    if (act === expv) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s step %0d: got %0h, expected %0h", name, id, act, expv);
    end
  endtask

  // Monitor: one scoreboard entry per rclk edge, sampled 1 time unit after the edge.
  always @(posedge rclk) begin
    #1;
    if (sb.size() != 0) begin
      mon_cur = sb.pop_front();
`ifndef RPTR_LEVEL_EN
      mon_cur.level = 5'd0;
      mon_cur.ae    = mon_cur.empty;
`endif
      checkOutput("raddr",         mon_cur.id, 32'(raddr),         32'(mon_cur.raddr));
      checkOutput("rptr_gray",     mon_cur.id, 32'(rptr_gray),     32'(mon_cur.gray));
      checkOutput("rempty",        mon_cur.id, 32'(rempty),        32'(mon_cur.empty));
      checkOutput("ralmost_empty", mon_cur.id, 32'(ralmost_empty), 32'(mon_cur.ae));
      checkOutput("rlevel",        mon_cur.id, 32'(rlevel),        32'(mon_cur.level));
      checkOutput("runderflow",    mon_cur.id, 32'(runderflow),    32'(mon_cur.uf));
    end
  end

  // Directed sequence; each applyStimulus call is exactly one rclk edge.
  initial begin
    exp_t rstv;
    rst_n     = 1'b0;
    rinc      = 1'b0;
    wptr_gray = 5'd0;
    rstv      = mk(4'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0);

    // Reset with rinc high and a nonzero write pointer; wptr reappears two edges after release.
    applyStimulus(1'b0, 1'b1, 5'b00110, rstv);
    applyStimulus(1'b0, 1'b1, 5'b00110, rstv);
    applyStimulus(1'b1, 1'b0, 5'b00110, rstv);
    applyStimulus(1'b1, 1'b0, 5'b00110, rstv);
    applyStimulus(1'b1, 1'b0, 5'b00110, mk(4'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b0));

    // Write pointer stepped through Gray 1, 3, 2 with no reads.
    applyStimulus(1'b0, 1'b0, 5'b00000, rstv);
    applyStimulus(1'b0, 1'b0, 5'b00000, rstv);
    applyStimulus(1'b1, 1'b0, 5'b00001, rstv);
    applyStimulus(1'b1, 1'b0, 5'b00011, rstv);
    applyStimulus(1'b1, 1'b0, 5'b00010, mk(4'd0, 5'd0, 1'b0, 1'b1, 5'd1, 1'b0));
    applyStimulus(1'b1, 1'b0, 5'b00010, mk(4'd0, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0));
    applyStimulus(1'b1, 1'b0, 5'b00010, mk(4'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b0));

    // Drain the three words.
    applyStimulus(1'b1, 1'b1, 5'b00010, mk(4'd1, 5'b00001, 1'b0, 1'b1, 5'd2, 1'b0));
    applyStimulus(1'b1, 1'b1, 5'b00010, mk(4'd2, 5'b00011, 1'b0, 1'b1, 5'd1, 1'b0));
    applyStimulus(1'b1, 1'b1, 5'b00010, mk(4'd3, 5'b00010, 1'b1, 1'b1, 5'd0, 1'b0));

    // Read while empty: pointers hold, underflow sticks through idle cycles.
    applyStimulus(1'b1, 1'b1, 5'b00010, mk(4'd3, 5'b00010, 1'b1, 1'b1, 5'd0, 1'b1));
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 5'b00010, mk(4'd3, 5'b00010, 1'b1, 1'b1, 5'd0, 1'b1));
    end

    // Fill to level 5, read once, then reset mid-drain.
    applyStimulus(1'b0, 1'b0, 5'b00000, rstv);
    applyStimulus(1'b0, 1'b0, 5'b00000, rstv);
    applyStimulus(1'b1, 1'b0, 5'b00111, rstv);
    applyStimulus(1'b1, 1'b0, 5'b00111, rstv);
    applyStimulus(1'b1, 1'b0, 5'b00111, mk(4'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0));
    applyStimulus(1'b1, 1'b1, 5'b00111, mk(4'd1, 5'b00001, 1'b0, 1'b0, 5'd4, 1'b0));
    applyStimulus(1'b0, 1'b1, 5'b00111, rstv);
    applyStimulus(1'b1, 1'b0, 5'b00000, rstv);

    // Wrap: 40 words, each written then read once it becomes visible.
    for (int k = 1; k <= 40; k++) begin
      applyStimulus(1'b1, 1'b0, g5(k), mk(4'(k - 1), g5(k - 1), 1'b1, 1'b1, 5'd0, 1'b0));
      applyStimulus(1'b1, 1'b0, g5(k), mk(4'(k - 1), g5(k - 1), 1'b1, 1'b1, 5'd0, 1'b0));
      applyStimulus(1'b1, 1'b0, g5(k), mk(4'(k - 1), g5(k - 1), 1'b0, 1'b1, 5'd1, 1'b0));
      applyStimulus(1'b1, 1'b1, g5(k), mk(4'(k), g5(k), 1'b1, 1'b1, 5'd0, 1'b0));
    end

    @(posedge rclk);
    #3;
    checkOutput("queue_drained", stepId, 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
